// File: rtl/score_digit_renderer.sv
// BCD score counter with per-frame snapshot and a 3-stage glyph renderer.
// Optional: SCORE_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module score_digit_renderer #(
    parameter int DIGITS = 4,
    parameter int X0     = 480,
    parameter int Y0     = 16,
    parameter int SCALE  = 4,
    parameter int GAP    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    input  logic                  score_inc,
    input  logic                  game_reset,
    output logic [3:0]            font_addr,
    input  logic [31:0]           font_data,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic                  pix_on
);
    localparam int GW = 8 * SCALE;
    localparam int P  = GW + GAP;
    localparam int GH = 4 * SCALE;
    localparam int SH = $clog2(SCALE);

    localparam logic [9:0] XL  = 10'(X0);
    localparam logic [9:0] XR  = 10'(X0 + DIGITS * P - GAP);
    localparam logic [9:0] YT  = 10'(Y0);
    localparam logic [9:0] YB  = 10'(Y0 + GH);
    localparam logic [9:0] PW  = 10'(P);
    localparam logic [9:0] GWW = 10'(GW);

    logic [4*DIGITS-1:0] score_q, score_d, inc_v, disp_q;
    logic [3:0]          font_addr_q;
    logic                v1_q, v2_q, pix_q;
    logic [2:0]          col1_q, col2_q;
    logic [1:0]          row1_q, row2_q;

    logic       carry, all9;
    logic [9:0] dx, dy, k, cx;
    logic       in_box, in_glyph, blk;
    logic [2:0] col;
    logic [1:0] row;
    logic [3:0] dig;
    logic [DIGITS-1:0] blank_v;

    always_comb begin
        inc_v = score_q;
        carry = 1'b1;
        all9  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (score_q[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    inc_v[4*i +: 4] = 4'd0;
                end else begin
                    inc_v[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        // Clear has priority; all-nines saturates.
        if (game_reset)              score_d = '0;
        else if (score_inc && !all9) score_d = inc_v;
        else                         score_d = score_q;
    end

    always_comb begin
        blank_v = '0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        begin
            logic z;
            z = 1'b1;
            for (int i = DIGITS - 1; i > 0; i--) begin
                z = z & (disp_q[4*i +: 4] == 4'd0);
                blank_v[i] = z;
            end
        end
`else
        blank_v = '0;
`endif
    end

    always_comb begin
        dx       = hcount - XL;
        dy       = vcount - YT;
        k        = dx / PW;
        cx       = dx % PW;
        in_box   = (hcount >= XL) && (hcount < XR) &&
                   (vcount >= YT) && (vcount < YB);
        in_glyph = in_box && (cx < GWW);
        col      = 3'(cx >> SH);
        row      = 2'(dy >> SH);
        dig      = 4'd0;
        blk      = 1'b0;
        // Glyph k (left to right) shows digit DIGITS-1-k.
        for (int i = 0; i < DIGITS; i++) begin
            if (k == 10'(DIGITS - 1 - i)) begin
                dig = disp_q[4*i +: 4];
                blk = blank_v[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score_q     <= '0;
            disp_q      <= '0;
            font_addr_q <= 4'd0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            pix_q       <= 1'b0;
            col1_q      <= 3'd0;
            col2_q      <= 3'd0;
            row1_q      <= 2'd0;
            row2_q      <= 2'd0;
        end else begin
            score_q <= score_d;
            if (hcount == 10'd0 && vcount == 10'd0) disp_q <= score_q;
            if (in_glyph) font_addr_q <= dig;
            v1_q   <= in_glyph && !blk;
            col1_q <= col;
            row1_q <= row;
            v2_q   <= v1_q;
            col2_q <= col1_q;
            row2_q <= row1_q;
            pix_q  <= v2_q & font_data[5'd31 - {row2_q, col2_q}];
        end
    end

    assign font_addr = font_addr_q;
    assign score_bcd = score_q;
    assign pix_on    = pix_q;
endmodule

// File: tb/tb_score_digit_renderer.sv
// Directed bench for score_digit_renderer with a registered font ROM model.
// Honours SCORE_LEADING_ZERO_BLANK_EN when defined for the build.
module tb_score_digit_renderer;
    localparam int DIGITS = 4;
    localparam int X0 = 480;
    localparam int Y0 = 16;
    localparam int SCALE = 4;
    localparam int GAP = 4;
    localparam int GW = 8 * SCALE;
    localparam int P = GW + GAP;
    localparam int GH = 4 * SCALE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  hcount = 10'd700;
    logic [9:0]  vcount = 10'd500;
    logic        score_inc = 1'b0;
    logic        game_reset = 1'b0;
    logic [3:0]  font_addr;
    logic [31:0] font_data = 32'd0;
    logic [15:0] score_bcd;
    logic        pix_on;

    int checks = 0;
    int failures = 0;
    int ink;
    logic [15:0] disp_m;
    logic [31:0] expq[$];

    score_digit_renderer #(
        .DIGITS(DIGITS), .X0(X0), .Y0(Y0), .SCALE(SCALE), .GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .score_inc(score_inc), .game_reset(game_reset),
        .font_addr(font_addr), .font_data(font_data),
        .score_bcd(score_bcd), .pix_on(pix_on)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [3:0] d);
        case (d)
            4'd0: rom = 32'h7E42427E;
            4'd1: rom = 32'h1808081C;
            4'd2: rom = 32'h7E027C7E;
            4'd3: rom = 32'h7E1E027E;
            4'd4: rom = 32'h42427E02;
            4'd5: rom = 32'h7E403E7E;
            4'd6: rom = 32'h7E407E7E;
            4'd7: rom = 32'h7E020408;
            4'd8: rom = 32'hFF81FFFF;
            4'd9: rom = 32'h7E427E02;
            default: rom = 32'h0;
        endcase
    endfunction

    always @(posedge clk) font_data <= rom(font_addr);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        hcount = 10'd700;
        vcount = 10'd500;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            score_inc = 1'b1;
            step();
            score_inc = 1'b0;
            step();
        end
    endtask

    task automatic clear_score();
        game_reset = 1'b1;
        step();
        game_reset = 1'b0;
    endtask

    task automatic snapshot();
        hcount = 10'd0;
        vcount = 10'd0;
        step();
        hcount = 10'd700;
        vcount = 10'd500;
    endtask

    function automatic int popcount(input logic [31:0] w);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(w[i]);
        return c;
    endfunction

    function automatic logic model_pix(input int h, input int v,
                                       input logic [15:0] d);
        logic [DIGITS-1:0] blank;
        logic z;
        logic res;
        logic [31:0] w;
        logic [3:0] dg;
        int c, r;
        blank = '0;
        res = 1'b0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        z = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            z = z & (d[4*i +: 4] == 4'd0);
            blank[i] = z;
        end
`else
        z = 1'b0;
`endif
        if (v >= Y0 && v < Y0 + GH) begin
            for (int g = 0; g < DIGITS; g++) begin
                if (h >= X0 + g * P && h < X0 + g * P + GW) begin
                    c = (h - X0 - g * P) / SCALE;
                    r = (v - Y0) / SCALE;
                    dg = d[4*(DIGITS-1-g) +: 4];
                    w = rom(dg);
                    res = !blank[DIGITS-1-g] && w[31 - 8*r - c];
                end
            end
        end
        return res;
    endfunction

    task automatic glyph_ink(input int g, output int n);
        n = 0;
        for (int v = Y0; v < Y0 + GH; v++) begin
            for (int h = X0 + g * P; h < X0 + g * P + GW; h++) begin
                hcount = 10'(h);
                vcount = 10'(v);
                step();
                n += int'(pix_on);
            end
        end
        hcount = 10'd700;
        vcount = 10'd500;
        for (int i = 0; i < 3; i++) begin
            step();
            n += int'(pix_on);
        end
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        check("rst_score", 32'(score_bcd), 32'h0);
        check("rst_addr", 32'(font_addr), 32'h0);
        check("rst_pix", 32'(pix_on), 32'h0);

        pulse(123);
        check("cnt_123", 32'(score_bcd), 32'h0123);
        pulse(10000 - 123);
        check("cnt_sat", 32'(score_bcd), 32'h9999);

        clear_score();
        pulse(457);
        check("cnt_457", 32'(score_bcd), 32'h0457);
        game_reset = 1'b1;
        score_inc = 1'b1;
        step();
        game_reset = 1'b0;
        score_inc = 1'b0;
        check("clr_wins", 32'(score_bcd), 32'h0);

        snapshot();
        pulse(1);
        check("snap_live", 32'(score_bcd), 32'h1);
        hcount = 10'(X0 + 3 * P);
        vcount = 10'(Y0);
        step();
        check("snap_hold", 32'(font_addr), 32'h0);
        idle(1);
        hcount = 10'd0;
        vcount = 10'd0;
        score_inc = 1'b1;
        step();
        score_inc = 1'b0;
        check("snap_inc", 32'(score_bcd), 32'h2);
        hcount = 10'(X0 + 3 * P);
        vcount = 10'(Y0);
        step();
        check("snap_pre", 32'(font_addr), 32'h1);
        idle(4);

        clear_score();
        pulse(8);
        snapshot();
        idle(4);
        hcount = 10'(X0 + 3 * P);
        vcount = 10'(Y0);
        step();
        check("d8_addr", 32'(font_addr), 32'h8);
        hcount = 10'd700;
        vcount = 10'd500;
        step();
        check("d8_early", 32'(pix_on), 32'h0);
        step();
        check("d8_pix", 32'(pix_on), 32'h1);
        idle(3);
        hcount = 10'(X0 + 32);
        vcount = 10'(Y0);
        step();
        idle(2);
        check("gap_pix", 32'(pix_on), 32'h0);

        clear_score();
        pulse(1234);
        snapshot();
        disp_m = 16'h1234;
        idle(4);
        expq.delete();
        for (int v = Y0 - 2; v < Y0 + GH + 2; v++) begin
            for (int h = X0 - 10; h < X0 + DIGITS * P + 6; h++) begin
                hcount = 10'(h);
                vcount = 10'(v);
                expq.push_back(32'(model_pix(h, v, disp_m)));
                step();
                if (expq.size() == 3) check("sweep", 32'(pix_on), expq.pop_front());
            end
        end
        hcount = 10'd700;
        vcount = 10'd500;
        for (int i = 0; i < 2; i++) begin
            expq.push_back(32'h0);
            step();
            if (expq.size() == 3) check("sweep", 32'(pix_on), expq.pop_front());
        end

        hcount = 10'(X0 + 3 * P);
        vcount = 10'(Y0);
        step();
        reset = 1'b1;
        hcount = 10'd700;
        vcount = 10'd500;
        step();
        reset = 1'b0;
        check("rst_mid_addr", 32'(font_addr), 32'h0);
        check("rst_mid_score", 32'(score_bcd), 32'h0);
        step();
        check("rst_kill", 32'(pix_on), 32'h0);
        step();
        check("rst_kill2", 32'(pix_on), 32'h0);

        pulse(42);
        snapshot();
        idle(4);
        glyph_ink(0, ink);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        check("lz_g0", 32'(ink), 32'h0);
`else
        check("lz_g0", 32'(ink), 32'(popcount(rom(4'd0)) * SCALE * SCALE));
`endif
        glyph_ink(1, ink);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        check("lz_g1", 32'(ink), 32'h0);
`else
        check("lz_g1", 32'(ink), 32'(popcount(rom(4'd0)) * SCALE * SCALE));
`endif
        glyph_ink(2, ink);
        check("lz_g2", 32'(ink), 32'(popcount(rom(4'd4)) * SCALE * SCALE));
        glyph_ink(3, ink);
        check("lz_g3", 32'(ink), 32'(popcount(rom(4'd2)) * SCALE * SCALE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
